// File: rtl/inlet_pump_sequencer.sv
// Inlet valve / peristaltic pump load sequencer: IDLE -> OPEN -> PUMP -> CLOSE -> DONE.
// Define PUMP_REVERSE_EN to add the dir input that runs the pump phase table backwards.
module inlet_pump_sequencer #(
  parameter int unsigned PHASE_CYCLES  = 16,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] inlet_sel,
  input  logic [7:0] stroke_count,
`ifdef PUMP_REVERSE_EN
  input  logic       dir,
`endif
  output logic [4:0] inlet_ctrl,
  output logic       prep_inlet_ctrl,
  output logic [2:0] pump,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned CNT_W      = 8;
  localparam int unsigned SEL_MAX    = 4;
  localparam logic [2:0]  LAST_PHASE = 3'd5;
  localparam logic [CNT_W-1:0] PHASE_LAST  = CNT_W'(PHASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_OPEN  = 3'd1,
    S_PUMP  = 3'd2,
    S_CLOSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_phase, w_phase_nxt;
  logic [7:0]       r_stroke, w_stroke_nxt;
  logic [2:0]       r_sel, w_sel_nxt;
  logic [7:0]       r_count, w_count_nxt;
  logic             r_dir, w_dir_nxt;
  logic [7:0]       w_stroke_inc;
  logic [2:0]       w_pump_idx;

  logic [4:0] r_inlet_ctrl, w_inlet_nxt;
  logic       r_prep, w_prep_nxt;
  logic [2:0] r_pump, w_pump_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_done, w_done_nxt;
  logic       r_error, w_error_nxt;

  assign w_stroke_inc = r_stroke + 8'd1;

  // Peristaltic phase table, bit0 = pump1, 1 = closed.
  function automatic logic [2:0] phase_pattern(input logic [2:0] idx);
    case (idx)
      3'd0:    phase_pattern = 3'b101;
      3'd1:    phase_pattern = 3'b100;
      3'd2:    phase_pattern = 3'b110;
      3'd3:    phase_pattern = 3'b010;
      3'd4:    phase_pattern = 3'b011;
      3'd5:    phase_pattern = 3'b001;
      default: phase_pattern = 3'b111;
    endcase
  endfunction

  // Next-state and next-output logic; outputs are computed from the next state so they register cleanly.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_phase_nxt  = r_phase;
    w_stroke_nxt = r_stroke;
    w_sel_nxt    = r_sel;
    w_count_nxt  = r_count;
    w_dir_nxt    = r_dir;
    w_error_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (32'(inlet_sel) <= SEL_MAX) begin
            w_state_nxt  = S_OPEN;
            w_sel_nxt    = inlet_sel;
            w_count_nxt  = stroke_count;
`ifdef PUMP_REVERSE_EN
            w_dir_nxt    = dir;
`else
            w_dir_nxt    = 1'b0;
`endif
            w_cnt_nxt    = '0;
            w_phase_nxt  = '0;
            w_stroke_nxt = '0;
          end else begin
            w_error_nxt = 1'b1;
          end
        end
      end
      S_OPEN: begin
        if (abort) begin
          w_state_nxt = S_CLOSE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == SETTLE_LAST) begin
          w_state_nxt = (r_count == 8'd0) ? S_CLOSE : S_PUMP;
          w_cnt_nxt   = '0;
          w_phase_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_PUMP: begin
        if (abort) begin
          w_state_nxt = S_CLOSE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == PHASE_LAST) begin
          w_cnt_nxt = '0;
          if (r_phase == LAST_PHASE) begin
            w_phase_nxt  = '0;
            w_stroke_nxt = w_stroke_inc;
            if (w_stroke_inc == r_count) begin
              w_state_nxt = S_CLOSE;
            end
          end else begin
            w_phase_nxt = r_phase + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_CLOSE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    w_pump_idx  = w_dir_nxt ? (LAST_PHASE - w_phase_nxt) : w_phase_nxt;
    w_inlet_nxt = 5'b11111;
    w_prep_nxt  = 1'b1;
    w_pump_nxt  = 3'b111;
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_done_nxt  = (w_state_nxt == S_DONE);

    case (w_state_nxt)
      S_OPEN: begin
        w_inlet_nxt = ~(5'd1 << w_sel_nxt);
        w_prep_nxt  = 1'b0;
      end
      S_PUMP: begin
        w_inlet_nxt = ~(5'd1 << w_sel_nxt);
        w_prep_nxt  = 1'b0;
        w_pump_nxt  = phase_pattern(w_pump_idx);
      end
      S_CLOSE: w_prep_nxt = 1'b0;
      default: ;
    endcase
  end

  // State, counters, captured fields and registered outputs; reset closes every valve at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_phase      <= '0;
      r_stroke     <= '0;
      r_sel        <= '0;
      r_count      <= '0;
      r_dir        <= 1'b0;
      r_inlet_ctrl <= 5'b11111;
      r_prep       <= 1'b1;
      r_pump       <= 3'b111;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_phase      <= w_phase_nxt;
      r_stroke     <= w_stroke_nxt;
      r_sel        <= w_sel_nxt;
      r_count      <= w_count_nxt;
      r_dir        <= w_dir_nxt;
      r_inlet_ctrl <= w_inlet_nxt;
      r_prep       <= w_prep_nxt;
      r_pump       <= w_pump_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_error      <= w_error_nxt;
    end
  end

  assign inlet_ctrl      = r_inlet_ctrl;
  assign prep_inlet_ctrl = r_prep;
  assign pump            = r_pump;
  assign busy            = r_busy;
  assign done            = r_done;
  assign error           = r_error;

endmodule

// File: tb/tb_inlet_pump_sequencer.sv
// Bench for inlet_pump_sequencer: vector table, hand sequences and randomized traces against
// a cycle-list reference model (reverse pumping exercised when PUMP_REVERSE_EN is defined).
module tb_inlet_pump_sequencer;

  localparam int PHASE  = 16;
  localparam int SETTLE = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [2:0] inlet_sel;
  logic [7:0] stroke_count;
`ifdef PUMP_REVERSE_EN
  logic       dir;
`endif
  logic [4:0] inlet_ctrl;
  logic       prep_inlet_ctrl;
  logic [2:0] pump;
  logic       busy;
  logic       done;
  logic       error;

  inlet_pump_sequencer #(.PHASE_CYCLES(PHASE), .SETTLE_CYCLES(SETTLE)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .inlet_sel       (inlet_sel),
    .stroke_count    (stroke_count),
`ifdef PUMP_REVERSE_EN
    .dir             (dir),
`endif
    .inlet_ctrl      (inlet_ctrl),
    .prep_inlet_ctrl (prep_inlet_ctrl),
    .pump            (pump),
    .busy            (busy),
    .done            (done),
    .error           (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] inlet;
    logic       prep;
    logic [2:0] pump;
    logic       busy;
    logic       done;
    logic       error;
  } out_t;

  typedef struct {
    int   sel;
    int   cnt;
    out_t exp;
  } vec_t;

  localparam out_t IDLE_O = {5'b11111, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0};

  int   n_tests = 0;
  int   n_fail  = 0;
  out_t exp_q[$];
  bit   ab_q[$];
  logic [2:0] fwd [6];

  function automatic out_t sample();
    return {inlet_ctrl, prep_inlet_ctrl, pump, busy, done, error};
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b (inlet|prep|pump|busy|done|error)", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Append one expected cycle; abortable cycles after the abort point are dropped.
  task automatic push(input out_t o, input bit ab, input int abort_at, inout bit cut);
    if (!(cut && ab)) begin
      exp_q.push_back(o);
      ab_q.push_back(ab);
      if (ab && (exp_q.size() - 1 == abort_at)) cut = 1'b1;
    end
  endtask

  // Reference: list of expected outputs per cycle, first entry = cycle after the start edge.
  task automatic build(input int sel, input int cnt, input int abort_at, input bit rev);
    out_t o, p;
    bit   cut = 1'b0;
    exp_q.delete();
    ab_q.delete();
    o       = IDLE_O;
    o.inlet = 5'b11111 ^ (5'b00001 << sel);
    o.prep  = 1'b0;
    o.busy  = 1'b1;
    for (int i = 0; i < SETTLE; i++) push(o, 1'b1, abort_at, cut);
    for (int s = 0; s < cnt; s++)
      for (int ph = 0; ph < 6; ph++)
        for (int c = 0; c < PHASE; c++) begin
          p      = o;
          p.pump = fwd[rev ? 5 - ph : ph];
          push(p, 1'b1, abort_at, cut);
        end
    p      = IDLE_O;
    p.prep = 1'b0;
    p.busy = 1'b1;
    for (int i = 0; i < SETTLE; i++) push(p, 1'b0, abort_at, cut);
    p      = IDLE_O;
    p.busy = 1'b1;
    p.done = 1'b1;
    push(p, 1'b0, abort_at, cut);
    push(IDLE_O, 1'b0, abort_at, cut);
  endtask

  // Launch one sequence and compare every cycle against the model; noise adds ignored start/abort/dir activity.
  task automatic run_trace(input string name, input int sel, input int cnt, input int abort_at,
                           input bit rev, input bit noise);
    int   bad = 0;
    int   first = -1;
    out_t fa, fe, a;
    build(sel, cnt, abort_at, rev);
    inlet_sel    = 3'(sel);
    stroke_count = 8'(cnt);
`ifdef PUMP_REVERSE_EN
    dir          = rev;
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      a = sample();
      if (a !== exp_q[k]) begin
        if (first < 0) begin
          first = k;
          fa    = a;
          fe    = exp_q[k];
        end
        bad++;
      end
      if (k < exp_q.size() - 1) begin
        abort = (k == abort_at) || (noise && !ab_q[k] && ($urandom % 4 == 0));
        if (noise) begin
          start        = 1'($urandom);
          inlet_sel    = 3'($urandom);
          stroke_count = 8'($urandom);
`ifdef PUMP_REVERSE_EN
          dir          = 1'($urandom);
`endif
        end
        tick();
      end
    end
    start = 1'b0;
    abort = 1'b0;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s: %0d bad cycles, first at cycle %0d got %b want %b", name, bad, first, fa, fe);
    end
  endtask

  // Abort an accepted sequence and wait (bounded) for its done pulse, then idle.
  task automatic abort_and_drain(input string name);
    int w = 0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    while (!done && w < 40) begin
      tick();
      w++;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_done: got done=%b want done=1 within 40 cycles", name, done);
    end
    tick();
    check({name, "_idle"}, sample(), IDLE_O);
  endtask

  vec_t vecs[8];

  initial begin
    fwd = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    vecs[0] = '{0, 2, {5'b11110, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0}};
    vecs[1] = '{1, 2, {5'b11101, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0}};
    vecs[2] = '{2, 3, {5'b11011, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0}};
    vecs[3] = '{3, 0, {5'b10111, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0}};
    vecs[4] = '{4, 255, {5'b01111, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0}};
    vecs[5] = '{5, 3, {5'b11111, 1'b1, 3'b111, 1'b0, 1'b0, 1'b1}};
    vecs[6] = '{6, 1, {5'b11111, 1'b1, 3'b111, 1'b0, 1'b0, 1'b1}};
    vecs[7] = '{7, 0, {5'b11111, 1'b1, 3'b111, 1'b0, 1'b0, 1'b1}};

    rst_n        = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    inlet_sel    = 3'd0;
    stroke_count = 8'd0;
`ifdef PUMP_REVERSE_EN
    dir          = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_hold", sample(), IDLE_O);
    rst_n = 1'b1;
    tick();
    check("reset_idle", sample(), IDLE_O);

    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_in_idle", sample(), IDLE_O);

    foreach (vecs[i]) begin
      inlet_sel    = 3'(vecs[i].sel);
      stroke_count = 8'(vecs[i].cnt);
      start = 1'b1;
      tick();
      start = 1'b0;
      check($sformatf("vec_sel%0d", vecs[i].sel), sample(), vecs[i].exp);
      if (vecs[i].exp.error) begin
        tick();
        check($sformatf("vec_err_clear%0d", vecs[i].sel), sample(), IDLE_O);
      end else begin
        abort_and_drain($sformatf("vec%0d", vecs[i].sel));
      end
    end

    run_trace("default_3_strokes", 2, 3, -1, 1'b0, 1'b0);
    run_trace("zero_strokes", 0, 0, -1, 1'b0, 1'b0);
    run_trace("abort_stroke1_phase3", 1, 2, SETTLE + 2 * PHASE + 4, 1'b0, 1'b0);
    run_trace("abort_at_open_end", 3, 1, SETTLE - 1, 1'b0, 1'b0);
    run_trace("abort_first_open", 4, 2, 0, 1'b0, 1'b0);
    run_trace("abort_last_pump_cycle", 0, 1, SETTLE + 6 * PHASE - 1, 1'b0, 1'b0);
`ifdef PUMP_REVERSE_EN
    run_trace("reverse_1_stroke", 3, 1, -1, 1'b1, 1'b0);
`endif
    run_trace("strokes_255", 4, 255, -1, 1'b0, 1'b1);

    for (int r = 0; r < 12; r++) begin
      bit rv = 1'b0;
      int ab = ($urandom % 2 == 0) ? int'($urandom % 350) : -1;
`ifdef PUMP_REVERSE_EN
      rv = 1'($urandom);
`endif
      run_trace($sformatf("random%0d", r), int'($urandom % 5), int'($urandom % 4), ab, rv, 1'b1);
    end

    // Reset asserted mid-PUMP must close everything without a clock edge.
    inlet_sel    = 3'd1;
    stroke_count = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    #2 rst_n = 1'b0;
    #1 check("reset_mid_pump", sample(), IDLE_O);
    @(negedge clk);
    #1 rst_n = 1'b1;
    inlet_sel    = 3'd3;
    stroke_count = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_after_reset", sample(), {5'b10111, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0});
    abort_and_drain("post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
